link_turn_scheduler: RTL and testbench
======================================

Name: link_turn_scheduler

Overview:
- Half-duplex turn controller sequencing one player's Encoder and Decoder over the shared optical link.
- Initiator transmits first; each side alternates SEND then LISTEN.
- Checks each received byte against the expected stream word, pulses success so upstream LFSR logic advances.
- On timeout, decode error or mismatch, retransmits the current word.

Parameters:
- N_PKT, 8, packet data width in bits.
- TIMEOUT, 1465, LISTEN cycles before retransmit (20-bit timer, 1..2^20-1).
- INITIATOR, 1, 1 = transmit first after reset; 0 = listen first.
- MAX_RETRY, 7, consecutive failed turns tolerated before link_fail sets (1..255).
- SETTLE, 2, cycles waited after a success pulse before sampling the new data2send (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data2send  in  N_PKT  word to transmit this turn
- data_expected  in  N_PKT  word the peer must deliver
- start_ENC  out  1  one-cycle Encoder start
- avail_ENC  in  1  Encoder idle/ready
- data_ENC  out  N_PKT  word presented to Encoder
- data_DEC  in  N_PKT  Decoder output word
- avail_DEC  in  1  Decoder word valid
- error_DEC  in  1  Decoder framing error, qualified by avail_DEC
- read_DEC  out  1  one-cycle Decoder consume
- expected_data_received  out  1  one-cycle success pulse
- err_code  out  2  last turn outcome: 00 ok, 01 timeout, 10 decode error, 11 mismatch
- link_fail  out  1  sticky; retry count exceeded MAX_RETRY
- ok_cnt, timeout_cnt, error_cnt  out  16 each  statistics (see Optional Feature)

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` asynchronous, active-low.
- Reset values: all outputs 0. State IDLE. retry_cnt 0, timer 0, synced flag 0.
- States: IDLE, SEND, WAIT_TX, LISTEN, CHECK, SETTLE.
- IDLE: next cycle goes to SEND if INITIATOR=1, else LISTEN.
- SEND:
  - Wait for avail_ENC=1.
  - In that cycle latch data_ENC<=data2send and pulse start_ENC for exactly 1 cycle.
  - Go to WAIT_TX.
  - data_ENC holds stable until the next SEND latch.
- WAIT_TX:
  - Ignore avail_ENC for the first 2 cycles (Encoder deassert latency).
  - Then wait for avail_ENC=1, clear timer, go to LISTEN.
  - Any avail_DEC in SEND/WAIT_TX is left unread; the Decoder holds it.
- LISTEN:
  - Timer increments each cycle.
  - avail_DEC=1 takes priority over timeout: go to CHECK.
  - Else timer==TIMEOUT-1 sets err_code=01 and runs the failure path.
  - Exception: the timer is frozen at 0 while INITIATOR=0 and synced=0, so the responder waits indefinitely for the first packet.
- CHECK:
  - Pulse read_DEC for 1 cycle; data_DEC and error_DEC are sampled this cycle.
  - error_DEC=1 sets err_code=10 and runs the failure path.
  - Else data_DEC!=data_expected sets err_code=11 and runs the failure path.
  - Else success: err_code=00, expected_data_received=1 for 1 cycle, retry_cnt=0, synced=1, go to SETTLE.
- Failure path:
  - retry_cnt increments, saturating at 255.
  - If retry_cnt becomes > MAX_RETRY, set link_fail (cleared only by reset).
  - Go to SEND, which retransmits the current data2send. Retrying continues after link_fail.
  - A responder with synced=0 that sees error or mismatch returns to LISTEN instead of SEND.
- SETTLE: wait SETTLE cycles, then go to SEND.
- err_code holds its value until the next outcome.
- Reset mid-transfer: immediate return to IDLE. Pending Decoder data is not consumed. start_ENC/read_DEC never glitch high.

Optional Feature:
- Macro: LINK_STATS_EN.
- Defined: ok_cnt, timeout_cnt, error_cnt are 16-bit saturating counters (stop at 16'hFFFF).
  - ok_cnt increments on each success.
  - timeout_cnt increments on each timeout.
  - error_cnt increments on each decode error or mismatch.
  - All reset to 0.
- Undefined: the three ports are tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- INITIATOR=1, avail_ENC=1, data2send=8'hA5 -> IDLE then SEND; start_ENC pulses 1 cycle with data_ENC=8'hA5; start_ENC does not repeat before LISTEN.
- After TX, avail_DEC=1 with data_DEC=data_expected=8'h3C and error_DEC=0 -> read_DEC 1 cycle; expected_data_received 1 cycle; err_code=00; next start_ENC comes SETTLE cycles later with the new data2send.
- TIMEOUT=100, no avail_DEC -> err_code=01 exactly 100 cycles after LISTEN entry, then retransmit of the same word; with LINK_STATS_EN, timeout_cnt=1.
- Responder (INITIATOR=0), no input for 10000 cycles -> no timeout, no start_ENC. Then data_DEC=8'h11 with expected 8'h12 -> err_code=11; returns to LISTEN without transmitting.
- MAX_RETRY=3, error_DEC=1 on every reply -> err_code=10; link_fail rises on the 4th consecutive failure and stays high through a later success.
- Assert rst_n=0 during WAIT_TX -> all outputs 0 asynchronously; after release, IDLE then SEND.

Source files
------------

// File: rtl/link_turn_scheduler.sv
// ---------------------------------------------------------------------------
// link_turn_scheduler
//
// Half-duplex turn controller for one player on a shared optical link.
// It alternates between driving the local Encoder (SEND) and waiting for the
// peer's word through the local Decoder (LISTEN). Each received word is
// compared with the expected stream word. A match produces a one-cycle
// success pulse so that upstream LFSR logic can advance. A timeout, a decode
// error or a mismatch makes the block retransmit the current word.
//
// Optional feature: define LINK_STATS_EN to build the three 16-bit saturating
// statistics counters. Without it the statistics ports are tied to zero.
//
// Parameters
//   N_PKT      packet data width
//   TIMEOUT    LISTEN cycles before a retransmit (1..2^20-1)
//   INITIATOR  1 = transmit first after reset, 0 = listen first
//   MAX_RETRY  consecutive failed turns tolerated before link_fail (1..255)
//   SETTLE     cycles waited after a success before sampling data2send (1..15)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   data2send                word to transmit this turn
//   data_expected            word the peer must deliver
//   start_ENC / avail_ENC    Encoder start pulse / Encoder ready
//   data_ENC                 word presented to the Encoder (held between sends)
//   data_DEC / avail_DEC     Decoder word / word valid
//   error_DEC                Decoder framing error (qualified by avail_DEC)
//   read_DEC                 one-cycle Decoder consume
//   expected_data_received   one-cycle success pulse
//   err_code                 last outcome: 00 ok, 01 timeout, 10 decode err, 11 mismatch
//   link_fail                sticky: retry count exceeded MAX_RETRY
//   ok_cnt/timeout_cnt/error_cnt  statistics
// ---------------------------------------------------------------------------
module link_turn_scheduler #(
    parameter int N_PKT     = 8,
    parameter int TIMEOUT   = 1465,
    parameter int INITIATOR = 1,
    parameter int MAX_RETRY = 7,
    parameter int SETTLE    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PKT-1:0] data2send,
    input  logic [N_PKT-1:0] data_expected,
    output logic             start_ENC,
    input  logic             avail_ENC,
    output logic [N_PKT-1:0] data_ENC,
    input  logic [N_PKT-1:0] data_DEC,
    input  logic             avail_DEC,
    input  logic             error_DEC,
    output logic             read_DEC,
    output logic             expected_data_received,
    output logic [1:0]       err_code,
    output logic             link_fail,
    output logic [15:0]      ok_cnt,
    output logic [15:0]      timeout_cnt,
    output logic [15:0]      error_cnt
);

    localparam logic [19:0] TIMER_LAST  = 20'(TIMEOUT - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);
    localparam bit          IS_INIT     = (INITIATOR != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_LISTEN,
        S_CHECK,
        S_SETTLE
    } state_t;

    state_t           r_state;
    logic [19:0]      r_timer;
    logic [7:0]       r_retry;
    logic             r_synced;
    logic [3:0]       r_wait;
    logic             r_start_enc;
    logic             r_read_dec;
    logic             r_ok_pulse;
    logic [1:0]       r_err_code;
    logic             r_link_fail;
    logic [N_PKT-1:0] r_data_enc;

    // An unsynchronised responder must wait forever for the first packet.
    logic       w_timer_frozen;
    logic       w_listen_to;
    logic       w_chk_ok;
    logic       w_chk_bad;
    logic       w_fail;
    logic [7:0] w_retry_inc;

    assign w_timer_frozen = !IS_INIT && !r_synced;
    // avail_DEC has priority over the timeout in the same cycle.
    assign w_listen_to = (r_state == S_LISTEN) && !avail_DEC && !w_timer_frozen &&
                         (r_timer == TIMER_LAST);
    assign w_chk_ok    = (r_state == S_CHECK) && !error_DEC && (data_DEC == data_expected);
    assign w_chk_bad   = (r_state == S_CHECK) && !w_chk_ok;
    assign w_fail      = w_listen_to || w_chk_bad;
    assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_retry     <= '0;
            r_synced    <= 1'b0;
            r_wait      <= '0;
            r_start_enc <= 1'b0;
            r_read_dec  <= 1'b0;
            r_ok_pulse  <= 1'b0;
            r_err_code  <= 2'b00;
            r_link_fail <= 1'b0;
            r_data_enc  <= '0;
        end else begin
            r_start_enc <= 1'b0;
            r_read_dec  <= 1'b0;
            r_ok_pulse  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    r_state <= IS_INIT ? S_SEND : S_LISTEN;
                end
                S_SEND: begin
                    if (avail_ENC) begin
                        r_data_enc  <= data2send;
                        r_start_enc <= 1'b1;
                        r_wait      <= '0;
                        r_state     <= S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    // The Encoder needs two cycles to drop avail_ENC after a start.
                    if (r_wait < 4'd2) begin
                        r_wait <= r_wait + 4'd1;
                    end else if (avail_ENC) begin
                        r_timer <= '0;
                        r_state <= S_LISTEN;
                    end
                end
                S_LISTEN: begin
                    if (avail_DEC) begin
                        r_read_dec <= 1'b1;
                        r_state    <= S_CHECK;
                    end else if (w_listen_to) begin
                        r_err_code <= 2'b01;
                    end else if (!w_timer_frozen) begin
                        r_timer <= r_timer + 20'd1;
                    end
                end
                S_CHECK: begin
                    if (w_chk_ok) begin
                        r_err_code <= 2'b00;
                        r_ok_pulse <= 1'b1;
                        r_retry    <= '0;
                        r_synced   <= 1'b1;
                        r_wait     <= '0;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_err_code <= error_DEC ? 2'b10 : 2'b11;
                    end
                end
                S_SETTLE: begin
                    if (r_wait == SETTLE_LAST) begin
                        r_state <= S_SEND;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Shared failure path for timeout, decode error and mismatch.
            if (w_fail) begin
                r_retry <= w_retry_inc;
                if (w_retry_inc > RETRY_LIMIT) begin
                    r_link_fail <= 1'b1;
                end
                if (w_chk_bad && w_timer_frozen) begin
                    r_timer <= '0;
                    r_state <= S_LISTEN;
                end else begin
                    r_state <= S_SEND;
                end
            end
        end
    end

    assign start_ENC              = r_start_enc;
    assign read_DEC               = r_read_dec;
    assign data_ENC               = r_data_enc;
    assign expected_data_received = r_ok_pulse;
    assign err_code               = r_err_code;
    assign link_fail              = r_link_fail;

`ifdef LINK_STATS_EN
    logic [15:0] r_ok_cnt;
    logic [15:0] r_timeout_cnt;
    logic [15:0] r_error_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok_cnt      <= '0;
            r_timeout_cnt <= '0;
            r_error_cnt   <= '0;
        end else begin
            if (w_chk_ok && r_ok_cnt != 16'hFFFF)
                r_ok_cnt <= r_ok_cnt + 16'd1;
            if (w_listen_to && r_timeout_cnt != 16'hFFFF)
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            if (w_chk_bad && r_error_cnt != 16'hFFFF)
                r_error_cnt <= r_error_cnt + 16'd1;
        end
    end

    assign ok_cnt      = r_ok_cnt;
    assign timeout_cnt = r_timeout_cnt;
    assign error_cnt   = r_error_cnt;
`else
    assign ok_cnt      = 16'd0;
    assign timeout_cnt = 16'd0;
    assign error_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_link_turn_scheduler.sv
module tb_link_turn_scheduler;

    localparam int N   = 8;
    localparam int TO  = 100;   // initiator timeout
    localparam int MR  = 3;     // initiator max retry
    localparam int ST  = 2;     // settle cycles (both instances)
    localparam int RTO = 50;    // responder timeout

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // initiator instance signals
    logic         rst_n;
    logic [N-1:0] data2send, data_expected, data_ENC, data_DEC;
    logic         start_ENC, avail_ENC, avail_DEC, error_DEC, read_DEC, erx, link_fail;
    logic [1:0]   err_code;
    logic [15:0]  ok_cnt, timeout_cnt, error_cnt;

    // responder instance signals
    logic         rp_rst_n;
    logic [N-1:0] rp_data2send, rp_data_expected, rp_data_ENC, rp_data_DEC;
    logic         rp_start_ENC, rp_avail_ENC, rp_avail_DEC, rp_error_DEC, rp_read_DEC, rp_erx, rp_link_fail;
    logic [1:0]   rp_err_code;
    logic [15:0]  rp_ok_cnt, rp_timeout_cnt, rp_error_cnt;

    link_turn_scheduler #(.N_PKT(N), .TIMEOUT(TO), .INITIATOR(1), .MAX_RETRY(MR), .SETTLE(ST)) u_init (
        .clk(clk), .rst_n(rst_n), .data2send(data2send), .data_expected(data_expected),
        .start_ENC(start_ENC), .avail_ENC(avail_ENC), .data_ENC(data_ENC),
        .data_DEC(data_DEC), .avail_DEC(avail_DEC), .error_DEC(error_DEC), .read_DEC(read_DEC),
        .expected_data_received(erx), .err_code(err_code), .link_fail(link_fail),
        .ok_cnt(ok_cnt), .timeout_cnt(timeout_cnt), .error_cnt(error_cnt)
    );

    link_turn_scheduler #(.N_PKT(N), .TIMEOUT(RTO), .INITIATOR(0), .MAX_RETRY(7), .SETTLE(ST)) u_resp (
        .clk(clk), .rst_n(rp_rst_n), .data2send(rp_data2send), .data_expected(rp_data_expected),
        .start_ENC(rp_start_ENC), .avail_ENC(rp_avail_ENC), .data_ENC(rp_data_ENC),
        .data_DEC(rp_data_DEC), .avail_DEC(rp_avail_DEC), .error_DEC(rp_error_DEC), .read_DEC(rp_read_DEC),
        .expected_data_received(rp_erx), .err_code(rp_err_code), .link_fail(rp_link_fail),
        .ok_cnt(rp_ok_cnt), .timeout_cnt(rp_timeout_cnt), .error_cnt(rp_error_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the link should report after each turn.
    logic [N-1:0] m_d2s;
    logic [1:0]   m_err;
    int           m_retry;
    bit           m_fail;
    int           m_ok, m_to, m_er;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_fail();
        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
        if (m_retry > MR) m_fail = 1'b1;
    endtask

    task automatic model_reset();
        m_err = 2'b00; m_retry = 0; m_fail = 1'b0;
        m_ok = 0; m_to = 0; m_er = 0;
    endtask

    // Ticks until start_ENC is seen or the budget runs out; n = ticks taken.
    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!start_ENC && n < max);
    endtask

    task automatic drive_reply(input int kind, input logic [N-1:0] exp_w);
        avail_DEC = 1'b1;
        error_DEC = (kind == 2);
        case (kind)
            0:       data_DEC = exp_w;
            1:       data_DEC = exp_w ^ 8'($urandom_range(1, 255));
            default: data_DEC = 8'($urandom);
        endcase
    endtask

    // One turn, entered on the cycle where start_ENC is high.
    // kind: 0 ok, 1 mismatch, 2 decode error, 3 timeout.
    task automatic do_turn(input int kind, input bit early, input logic [N-1:0] exp_w);
        int  k, lrel, arel, rrel, r, n;
        bit  seen_read, dup;
        check_val("tx_word", data_ENC, m_d2s);
        k    = $urandom_range(0, 4);                  // Encoder busy cycles after start
        lrel = ((k > 2) ? k : 2) + 1;                 // first LISTEN cycle
        data_expected = exp_w;
        if (kind == 3) begin
            arel = -1;
            rrel = lrel + TO;                         // cycle err_code shows timeout
        end else if (early) begin
            arel = 0;
            rrel = lrel + 1;
        end else begin
            arel = lrel + $urandom_range(0, 30);
            rrel = arel + 1;
        end
        r = 0; seen_read = 0; dup = 0;
        avail_ENC = (k == 0);
        if (arel == 0) drive_reply(kind, exp_w);
        while (r < rrel) begin
            tick();
            r++;
            avail_ENC = (r >= k);
            if (start_ENC) dup = 1;
            if (read_DEC && (r < rrel || kind == 3)) seen_read = 1;
            if (r == arel) drive_reply(kind, exp_w);
            if (kind == 3 && r == rrel - 1) check_val("err_hold", err_code, m_err);
        end
        check_val("no_restart", dup, 0);
        check_val("no_early_read", seen_read, 0);
        if (kind == 3) begin
            m_err = 2'b01; m_to++; model_fail();
            check_val("timeout_code", err_code, m_err);
            check_val("link_fail", link_fail, m_fail);
            wait_start(10, n);
            check_val("retx_gap_to", n, 1);
        end else begin
            check_val("read_lat", read_DEC, 1);
            tick();
            avail_DEC = 1'b0; error_DEC = 1'b0; data_DEC = 8'($urandom);
            if (kind == 0) begin
                m_err = 2'b00; m_retry = 0; m_ok++;
            end else begin
                m_err = (kind == 1) ? 2'b11 : 2'b10; m_er++; model_fail();
            end
            check_val("err_code", err_code, m_err);
            check_val("ok_pulse", erx, (kind == 0));
            check_val("link_fail", link_fail, m_fail);
            if (kind == 0) begin
                m_d2s = 8'($urandom);
                data2send = m_d2s;
                tick();
                check_val("ok_pulse_len", erx, 0);
                wait_start(20, n);
                check_val("settle_gap", n, ST);
            end else begin
                wait_start(10, n);
                check_val("retx_gap", n, 1);
            end
        end
    endtask

    initial begin
        int n, kind, cnt_s, cnt_r;
        bit early;
        // ---------------- initiator ----------------
        rst_n = 1'b0; rp_rst_n = 1'b0;
        avail_ENC = 1'b1; avail_DEC = 1'b0; error_DEC = 1'b0;
        data2send = 8'hA5; data_expected = 8'h00; data_DEC = 8'h00;
        rp_avail_ENC = 1'b1; rp_avail_DEC = 1'b0; rp_error_DEC = 1'b0;
        rp_data2send = 8'h00; rp_data_expected = 8'h00; rp_data_DEC = 8'h00;
        model_reset();
        m_d2s = 8'hA5;
        tick(); tick();
        check_val("rst_start", start_ENC, 0);
        check_val("rst_data_enc", data_ENC, 0);
        check_val("rst_read", read_DEC, 0);
        check_val("rst_erx", erx, 0);
        check_val("rst_err", err_code, 0);
        check_val("rst_fail", link_fail, 0);
        check_val("rst_rp_start", rp_start_ENC, 0);
        rst_n = 1'b1;
        wait_start(10, n);
        check_val("idle_to_send", n, 2);

        do_turn(0, 0, 8'h3C);                             // first ok exchange
        do_turn(3, 0, 8'($urandom));                      // timeout + retransmit
        for (int i = 0; i < 4; i++) do_turn(2, 0, 8'($urandom));   // link_fail on 4th
        do_turn(0, 0, 8'($urandom));                      // link_fail stays
        do_turn(1, 1, 8'($urandom));                      // early Decoder word, mismatch
        for (int i = 0; i < 24; i++) begin
            kind  = $urandom_range(0, 3);
            early = (kind != 3) && ($urandom_range(0, 3) == 0);
            do_turn(kind, early, 8'($urandom));
        end

`ifdef LINK_STATS_EN
        check_val("ok_cnt", ok_cnt, m_ok);
        check_val("timeout_cnt", timeout_cnt, m_to);
        check_val("error_cnt", error_cnt, m_er);
`else
        check_val("ok_cnt_tied", ok_cnt, 0);
        check_val("timeout_cnt_tied", timeout_cnt, 0);
        check_val("error_cnt_tied", error_cnt, 0);
`endif

        // Reset in the middle of WAIT_TX (we are on a start_ENC cycle).
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_start", start_ENC, 0);
        check_val("arst_data_enc", data_ENC, 0);
        check_val("arst_read", read_DEC, 0);
        check_val("arst_erx", erx, 0);
        check_val("arst_err", err_code, 0);
        check_val("arst_fail", link_fail, 0);
        check_val("arst_stats", {ok_cnt, error_cnt}, 0);
        model_reset();
        m_d2s = 8'($urandom);
        data2send = m_d2s;
        avail_ENC = 1'b1;
        tick();
        rst_n = 1'b1;
        wait_start(10, n);
        check_val("arst_idle_to_send", n, 2);
        check_val("arst_tx_word", data_ENC, m_d2s);

        // ---------------- responder ----------------
        tick();
        rp_rst_n = 1'b1;
        cnt_s = 0; cnt_r = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (rp_start_ENC) cnt_s++;
            if (rp_read_DEC)  cnt_r++;
        end
        check_val("rsp_wait_start", cnt_s, 0);
        check_val("rsp_wait_read", cnt_r, 0);
        check_val("rsp_wait_err", rp_err_code, 0);

        rp_data_expected = 8'h12; rp_data_DEC = 8'h11; rp_avail_DEC = 1'b1;
        tick();
        check_val("rsp_read1", rp_read_DEC, 1);
        tick();
        rp_avail_DEC = 1'b0;
        check_val("rsp_mismatch", rp_err_code, 2'b11);
        check_val("rsp_mis_erx", rp_erx, 0);
        cnt_s = 0; cnt_r = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rp_start_ENC) cnt_s++;
            if (rp_read_DEC)  cnt_r++;
        end
        check_val("rsp_relisten_start", cnt_s, 0);
        check_val("rsp_relisten_read", cnt_r, 0);

        rp_data_expected = 8'h5A; rp_data_DEC = 8'h5A; rp_avail_DEC = 1'b1;
        tick();
        check_val("rsp_read2", rp_read_DEC, 1);
        tick();
        rp_avail_DEC = 1'b0;
        rp_data2send = 8'hC7;
        check_val("rsp_ok_erx", rp_erx, 1);
        check_val("rsp_ok_err", rp_err_code, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rp_start_ENC && n < 20);
        check_val("rsp_settle_gap", n, ST + 1);
        check_val("rsp_tx_word", rp_data_ENC, 8'hC7);
        // Now synced: timeout is live. LISTEN starts 3 cycles after start_ENC.
        for (int i = 0; i < RTO + 2; i++) tick();
        check_val("rsp_err_hold", rp_err_code, 0);
        tick();
        check_val("rsp_timeout", rp_err_code, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
